inst_fetch: RTL and testbench

Instruction-fetch initiator for the five-stage MIPS pipeline. It owns the program counter and drives the chip-enable and byte address of the combinational instruction ROM. It forwards the returned word, together with its PC, to the IF/ID register. It resolves redirects in priority order (exception flush, then branch, then sequential) and holds a redirect that arrives while fetch is stalled until the stall releases.

---
 rtl/inst_fetch_pkg.sv | 32 +++
 rtl/inst_fetch_pc_next_sel.sv | 48 ++++
 rtl/inst_fetch.sv | 132 +++++++++++++
 tb/tb_inst_fetch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// ============================================================================
// Module      : inst_fetch_pkg
// Description : Shared definitions for the instruction-fetch stage: address
//               and data widths, chip-enable levels, zero word and the fetch
//               state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_fetch_pkg;

    // Instruction address and data widths
    localparam int INST_ADDR_W = 32;
    localparam int INST_DATA_W = 32;

    // ROM chip-enable levels
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    // Word driven onto the instruction bus when nothing real is fetched
    localparam logic [INST_DATA_W-1:0] ZERO_WORD = '0;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

endpackage : inst_fetch_pkg

`default_nettype wire

// File: rtl/inst_fetch_pc_next_sel.sv
// ============================================================================
// Module      : pc_next_sel
// Description : Combinational next-PC priority mux for the fetch stage.
//               Priority: flush > stall (hold) > branch > pending > sequential.
//               A live branch beats a pending redirect on the consuming edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_sel
    import inst_fetch_pkg::*;
#(
    parameter int unsigned PC_STEP = 4
) (
    input  logic [INST_ADDR_W-1:0] i_pc,
    input  logic                   i_flush,
    input  logic [INST_ADDR_W-1:0] i_new_pc,
    input  logic                   i_stall,
    input  logic                   i_pend_valid,
    input  logic [INST_ADDR_W-1:0] i_pend_target,
    input  logic                   i_branch_flag,
    input  logic [INST_ADDR_W-1:0] i_branch_target,
    output logic [INST_ADDR_W-1:0] o_next_pc
);

    localparam logic [INST_ADDR_W-1:0] c_pc_step = INST_ADDR_W'(PC_STEP);

    // Sequential increment wraps modulo 2^32; carry out is discarded
    logic [INST_ADDR_W-1:0] w_seq_pc;
    assign w_seq_pc = i_pc + c_pc_step;

    // Priority select of the next fetch address
    always_comb begin
        o_next_pc = w_seq_pc;
        if (i_flush) begin
            o_next_pc = i_new_pc;
        end else if (i_stall) begin
            o_next_pc = i_pc;
        end else if (i_branch_flag) begin
            o_next_pc = i_branch_target;
        end else if (i_pend_valid) begin
            o_next_pc = i_pend_target;
        end
    end

endmodule : pc_next_sel

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module      : inst_fetch
// Description : Instruction-fetch initiator. Owns the PC, drives the ROM
//               chip enable and byte address, forwards the fetched word and
//               PC to IF/ID, and holds a redirect that arrives during a stall
//               until the stall releases.
//               Optional feature macro: FETCH_ALIGN_CHK_EN (misaligned-fetch
//               detection on exc_adel).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] new_pc,
    input  logic                   branch_flag,
    input  logic [INST_ADDR_W-1:0] branch_target,
    output logic                   rom_ce,
    output logic [INST_ADDR_W-1:0] rom_addr,
    input  logic [INST_DATA_W-1:0] rom_inst,
    output logic [INST_ADDR_W-1:0] pc,
    output logic [INST_DATA_W-1:0] inst,
    output logic                   valid,
    output logic                   exc_adel
);

    fetch_state_e           r_state;
    fetch_state_e           w_state_next;
    logic [INST_ADDR_W-1:0] r_pc;
    logic [INST_ADDR_W-1:0] w_pc_next;
    logic                   r_pend_valid;
    logic [INST_ADDR_W-1:0] r_pend_target;
    logic                   w_active;
    logic                   w_misaligned;

    // Fetching is live in every state except the post-reset idle cycle
    assign w_active = (r_state != FETCH_IDLE);

    pc_next_sel #(
        .PC_STEP (PC_STEP)
    ) u_pc_next_sel (
        .i_pc            (r_pc),
        .i_flush         (flush),
        .i_new_pc        (new_pc),
        .i_stall         (stall),
        .i_pend_valid    (r_pend_valid),
        .i_pend_target   (r_pend_target),
        .i_branch_flag   (branch_flag),
        .i_branch_target (branch_target),
        .o_next_pc       (w_pc_next)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: stall selects HOLD from any state, otherwise RUN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH_IDLE: w_state_next = stall ? FETCH_HOLD : FETCH_RUN;
            FETCH_RUN:  w_state_next = stall ? FETCH_HOLD : FETCH_RUN;
            FETCH_HOLD: w_state_next = stall ? FETCH_HOLD : FETCH_RUN;
            default:    w_state_next = FETCH_IDLE;
        endcase
    end

    // PC register: frozen at RESET_PC through the idle cycle, then follows the mux
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (w_active) begin
            r_pc <= w_pc_next;
        end
    end

    // Pending redirect: captured during a stall, dropped on flush or once consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else if (w_active) begin
            if (flush) begin
                r_pend_valid <= 1'b0;
            end else if (stall) begin
                if (branch_flag) begin
                    r_pend_valid  <= 1'b1;
                    r_pend_target <= branch_target;
                end
            end else begin
                r_pend_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    // A live fetch from a non-word-aligned PC raises an address-error flag
    assign w_misaligned = w_active && (r_pc[1:0] != 2'b00);
`else
    // Low PC bits go to the ROM unchecked
    assign w_misaligned = 1'b0;
`endif

    // Output drive: ROM interface, fetched word and qualifiers
    always_comb begin
        rom_ce   = w_active ? CHIP_ENABLE : CHIP_DISABLE;
        rom_addr = r_pc;
        pc       = r_pc;
        inst     = ZERO_WORD;
        if (w_active && !w_misaligned) begin
            inst = rom_inst;
        end
        valid    = w_active && !flush;
        exc_adel = w_misaligned;
    end

endmodule : inst_fetch

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch: a table of per-cycle
//               inputs and expected pc/ce/valid, plus hand-written sequences
//               for async reset mid-stream and misaligned fetch
//               (FETCH_ALIGN_CHK_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        exc_adel;

    int n_checks;
    int n_errors;

    logic [31:0] mem [0:63];

    inst_fetch #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .pc            (pc),
        .inst          (inst),
        .valid         (valid),
        .exc_adel      (exc_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ROM: small preloaded array, hashed words elsewhere; addr[1:0] ignored
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a[31:8] == 24'h0) return mem[a[7:2]];
        return {a[31:2], 2'b00} ^ 32'h5A5A_5A5A;
    endfunction

    always_comb rom_inst = rom_word(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        br;
        logic [31:0] br_tgt;
        logic [31:0] exp_pc;
        logic        exp_ce;
        logic        exp_valid;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic s, input logic f, input logic [31:0] np,
                                input logic b, input logic [31:0] bt,
                                input logic [31:0] epc, input logic ece, input logic ev);
        vec_t v;
        v.stall = s; v.flush = f; v.new_pc = np; v.br = b; v.br_tgt = bt;
        v.exp_pc = epc; v.exp_ce = ece; v.exp_valid = ev;
        return v;
    endfunction

    task automatic drive(input logic s, input logic f, input logic [31:0] np,
                         input logic b, input logic [31:0] bt);
        stall = s; flush = f; new_pc = np; branch_flag = b; branch_target = bt;
    endtask

    // Full output check for one cycle of an aligned fetch
    task automatic chk_cycle(input string tag, input logic [31:0] epc,
                             input logic ece, input logic ev);
        chk({tag, ".pc"},       pc,       epc);
        chk({tag, ".rom_addr"}, rom_addr, epc);
        chk({tag, ".rom_ce"},   {31'h0, rom_ce}, {31'h0, ece});
        chk({tag, ".valid"},    {31'h0, valid},  {31'h0, ev});
        chk({tag, ".inst"},     inst, ece ? rom_word(epc) : 32'h0);
        chk({tag, ".exc_adel"}, {31'h0, exc_adel}, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h2400_0000 + 32'(i) * 32'h0001_0011;

        //            stall flush new_pc        br  br_tgt        exp_pc        ce  valid
        vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0); // idle cycle
        vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 1); // edge 1
        vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 1, 1);
        vecs[3]  = mk(0, 0, 32'h0,        1, 32'h40,       32'h0000_0008, 1, 1); // branch
        vecs[4]  = mk(0, 0, 32'h0,        0, 32'h0,        32'h0000_0040, 1, 1);
        vecs[5]  = mk(0, 0, 32'h0,        0, 32'h0,        32'h0000_0044, 1, 1);
        vecs[6]  = mk(0, 0, 32'h0,        1, 32'h10,       32'h0000_0048, 1, 1);
        vecs[7]  = mk(1, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 1, 1); // stall 1
        vecs[8]  = mk(1, 0, 32'h0,        1, 32'h80,       32'h0000_0010, 1, 1); // stall 2 + br
        vecs[9]  = mk(1, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 1, 1); // stall 3
        vecs[10] = mk(0, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 1, 1); // release
        vecs[11] = mk(0, 0, 32'h0,        0, 32'h0,        32'h0000_0080, 1, 1); // pending taken
        vecs[12] = mk(1, 0, 32'h0,        1, 32'h60,       32'h0000_0084, 1, 1); // pending set
        vecs[13] = mk(1, 1, 32'h20,       1, 32'h40,       32'h0000_0084, 1, 0); // flush+br+stall
        vecs[14] = mk(0, 0, 32'h0,        0, 32'h0,        32'h0000_0020, 1, 1);
        vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,        32'h0000_0024, 1, 1); // pending gone
        vecs[16] = mk(1, 0, 32'h0,        1, 32'h100,      32'h0000_0028, 1, 1);
        vecs[17] = mk(0, 0, 32'h0,        1, 32'h200,      32'h0000_0028, 1, 1); // live br wins
        vecs[18] = mk(0, 0, 32'h0,        0, 32'h0,        32'h0000_0200, 1, 1);
        vecs[19] = mk(0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'h0000_0204, 1, 1);
        vecs[20] = mk(0, 0, 32'h0,        0, 32'h0,        32'hFFFF_FFFC, 1, 1);
        vecs[21] = mk(0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 1); // wrap
        vecs[22] = mk(0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 1, 1);

        // Reset state
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cycle("reset", 32'h0, 1'b0, 1'b0);

        // Release reset just after an edge, then walk the table
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].new_pc, vecs[i].br, vecs[i].br_tgt);
            @(negedge clk);
            chk_cycle($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_ce, vecs[i].exp_valid);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 32'h0, 0, 32'h0);

        // Asynchronous reset mid-stream takes effect before the next edge
        #1 rst = 1'b1;
        #1;
        chk("async_rst.rom_ce", {31'h0, rom_ce}, 32'h0);
        chk("async_rst.pc",     pc,              32'h0);
        chk("async_rst.valid",  {31'h0, valid},  32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_cycle("post_rst_idle", 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        // Pending must have been cleared by reset: a stale one would redirect here
        @(negedge clk);
        chk_cycle("post_rst_e1", 32'h0, 1'b1, 1'b1);

        // Misaligned branch target
        @(posedge clk);
        #1 drive(0, 0, 32'h0, 1, 32'h42);
        @(posedge clk);
        #1 drive(0, 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        chk("adel.pc",    pc,             32'h42);
        chk("adel.valid", {31'h0, valid}, 32'h1);
`ifdef FETCH_ALIGN_CHK_EN
        chk("adel.exc_adel", {31'h0, exc_adel}, 32'h1);
        chk("adel.inst",     inst,              32'h0);
`else
        chk("adel.exc_adel", {31'h0, exc_adel}, 32'h0);
        chk("adel.inst",     inst,              rom_word(32'h42));
`endif
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("adel.next_pc", pc, 32'h46);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_inst_fetch

`default_nettype wire
